response_collector_mt: RTL and testbench
========================================

Name: response_collector_mt

Overview:
- Multi-outstanding successor to the single-reduction response collector.
- Tracks up to NUM_CTX concurrent READ reductions, each with its own tag. Matches tagged port responses to the correct context and buffers them per context and per port.
- Streams values to the reduction engine one reduction at a time, oldest first, never interleaving two reductions.
- Sits between the read requester / port interfaces and the reduction engine.

Parameters:
- NUM_PORTS, 4, number of switch ports; PORT_BITS = $clog2(NUM_PORTS).
- NUM_CTX, 4, outstanding reduction contexts (power of 2, ≥2); CTX_BITS = $clog2(NUM_CTX).
- TIMEOUT_CYCLES, 1024, stall limit for the head context; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pending_valid  in  1  new reduction request.
- pending_mask  in  NUM_PORTS  ports expected to respond.
- pending_tag  in  TAG_WIDTH  reduction tag.
- pending_src_port  in  PORT_BITS  originating port.
- pending_ready  out  1  request accepted when high with valid.
- port_data_valid  in  NUM_PORTS  per-port response valid.
- port_data  in  DATA_WIDTH x NUM_PORTS  per-port response data.
- port_data_tag  in  TAG_WIDTH x NUM_PORTS  per-port response tag.
- port_data_ready  out  NUM_PORTS  per-port response accept.
- rsp_drop  out  NUM_PORTS  1-cycle pulse: response accepted and discarded.
- value_valid  out  1  value to reduction engine.
- value_data  out  DATA_WIDTH  value.
- value_tag  out  TAG_WIDTH  tag of current (head) context.
- value_src_port  out  PORT_BITS  source port of head context.
- value_last  out  1  final value of this reduction.
- value_timeout  out  1  value is a timeout terminator.
- value_ready  in  1  reduction engine accept.
- active_count  out  CTX_BITS+1  allocated contexts.
- busy  out  1  active_count != 0.

Behaviour:
- Reset (rst sampled high on clk edge):
  - All contexts invalid, head = tail = 0, active_count = 0, per-context round-robin pointers = NUM_PORTS-1.
  - Outputs: pending_ready = 1, port_data_ready = 0, value_valid = 0, value_last = 0, value_timeout = 0, rsp_drop = 0, busy = 0.
  - Reset mid-operation discards all contexts and buffered data without emitting anything.
- Contexts form a ring. Allocation at tail, service and retire at head.
  - Each context holds: valid, expected_mask, received_mask, buffered_mask, tag, src_port, NUM_PORTS data slots.
- Allocation:
  - pending_ready = (active_count < NUM_CTX) && (no valid context has tag == pending_tag).
  - On handshake, if pending_mask != 0: allocate at tail, masks cleared, tail++.
  - If pending_mask == 0: request accepted and ignored, no context allocated.
- Response match (combinational, per port p):
  - Hit = a valid context c with tag == port_data_tag[p] and expected_mask[p] set.
  - On hit: port_data_ready[p] = !buffered[c][p] && !received[c][p]; on accept, data is written to slot [c][p] and buffered[c][p] is set.
  - No hit (unknown tag, port not expected, or port already received): port_data_ready[p] = 1, response discarded, rsp_drop[p] pulses.
  - A context allocated in cycle N is matchable from cycle N+1.
- Output path:
  - Only the head context drives the output. value_valid = head valid && (buffered & ~received) != 0.
  - Port selection is round-robin starting at rr_ptr+1.
  - Latency from port accept to value_valid is 1 cycle.
  - value_last = (received | onehot(sel)) == expected_mask.
  - On value handshake: received[sel] and rr_ptr are updated and buffered[sel] is cleared. If last, the context is invalidated and head++.
  - Non-head contexts keep buffering meanwhile; when they become head they may emit back-to-back, 1 value per cycle.
- Simultaneous events:
  - Allocate and retire in the same cycle: active_count is unchanged.
  - Response to slot [c][p] in the same cycle as send from [c][p]: not possible, because ready is low while buffered.
  - A tag retired in cycle N may be re-allocated in cycle N+1.
- Outputs are stable while value_valid && !value_ready.

Optional Feature:
- Macro RSP_TIMEOUT_EN.
- Defined:
  - A head stall counter increments each cycle the head is valid and has nothing sendable. It clears on any value handshake or head change.
  - When the count reaches TIMEOUT_CYCLES-1, the block presents value_valid = 1, value_data = 0, value_last = 1, value_timeout = 1.
  - On handshake the head context retires. Late responses carrying its tag are dropped via rsp_drop.
- Undefined: no counter; value_timeout is tied to 0; the head waits indefinitely.

Decomposition:
- tswitch_pkg: DATA_WIDTH and TAG_WIDTH (existing), plus a new typedef collector_ctx_t packing valid, tag, src_port and the three masks, sized by NUM_PORTS.
- Sub-module rr_select (NUM_PORTS): request vector + last pointer -> grant index + any.

Test Plan:
- Single context, mask 4'b1011, tag 5, responses on ports 3, 0, 1 -> values in rr order 0, 1, 3; last only on the third value; busy falls the cycle after.
- Contexts tag 1 (mask 0011) and tag 2 (mask 0100); port 2 responds to tag 2 first -> tag 2 value held until both tag 1 values drain, then emitted back-to-back with value_tag = 2, last = 1.
- Four contexts allocated -> pending_ready = 0; duplicate tag while not full -> pending_ready = 0; retire plus new pending in the same cycle -> active_count stays 4.
- Response with unknown tag 9 on port 2 -> port_data_ready[2] = 1 and rsp_drop[2] = 1 for 1 cycle; no state change.
- value_ready held low 5 cycles with value_valid high -> value_data and value_last stable; rst asserted mid-stream -> next cycle value_valid = 0, active_count = 0.
- RSP_TIMEOUT_EN, TIMEOUT_CYCLES = 16, mask 0011, only port 0 responds -> after 16 stalled cycles a value with data 0, last = 1, timeout = 1; a later port 1 response for that tag -> rsp_drop[1].

Source files
------------

// File: rtl/response_collector_mt_pkg.sv
// Shared types for the multi-outstanding response collector.
// Context record and bus widths live here.
package response_collector_mt_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 8;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_BITS  = $clog2(NUM_PORTS);

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [PORT_BITS-1:0] src_port;
    logic [NUM_PORTS-1:0] exp_mask;
    logic [NUM_PORTS-1:0] rcv_mask;
    logic [NUM_PORTS-1:0] buf_mask;
  } collector_ctx_t;

  function automatic logic [NUM_PORTS-1:0] onehot(
    input logic [PORT_BITS-1:0] idx
  );
    return NUM_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/response_collector_mt_if.sv
// Request, port-response and value buses of the collector.
// slave = collector side, master = environment side.
interface response_collector_mt_if #(
  parameter int NUM_CTX = 4
);
  import response_collector_mt_pkg::*;

  localparam int CTX_BITS = $clog2(NUM_CTX);

  logic                                 pending_valid;
  logic [NUM_PORTS-1:0]                 pending_mask;
  logic [TAG_WIDTH-1:0]                 pending_tag;
  logic [PORT_BITS-1:0]                 pending_src_port;
  logic                                 pending_ready;
  logic [NUM_PORTS-1:0]                 port_data_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;
  logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]  port_data_tag;
  logic [NUM_PORTS-1:0]                 port_data_ready;
  logic [NUM_PORTS-1:0]                 rsp_drop;
  logic                                 value_valid;
  logic [DATA_WIDTH-1:0]                value_data;
  logic [TAG_WIDTH-1:0]                 value_tag;
  logic [PORT_BITS-1:0]                 value_src_port;
  logic                                 value_last;
  logic                                 value_timeout;
  logic                                 value_ready;
  logic [CTX_BITS:0]                    active_count;
  logic                                 busy;

  modport master (
    output pending_valid, pending_mask, pending_tag,
    output pending_src_port, port_data_valid,
    output port_data, port_data_tag, value_ready,
    input  pending_ready, port_data_ready, rsp_drop,
    input  value_valid, value_data, value_tag,
    input  value_src_port, value_last, value_timeout,
    input  active_count, busy
  );

  modport slave (
    input  pending_valid, pending_mask, pending_tag,
    input  pending_src_port, port_data_valid,
    input  port_data, port_data_tag, value_ready,
    output pending_ready, port_data_ready, rsp_drop,
    output value_valid, value_data, value_tag,
    output value_src_port, value_last, value_timeout,
    output active_count, busy
  );

endinterface

// File: rtl/response_collector_mt_rr_select.sv
// Round-robin picker: first set request after last_i, wrapping.
// any_o is low when no request is set.
module response_collector_mt_rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 any_o
);
  localparam int W = $clog2(N);

  logic [W-1:0] idx;

  // scan from last_i+1 round the ring, keep first hit
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/response_collector_mt.sv
// Multi-context response collector; head context streams values.
// Optional head stall timeout enabled by RSP_TIMEOUT_EN.
module response_collector_mt
  import response_collector_mt_pkg::*;
#(
  parameter int NUM_CTX = 4
`ifdef RSP_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  response_collector_mt_if.slave bus
);
  localparam int CTX_BITS = $clog2(NUM_CTX);

  collector_ctx_t        ctx_q [NUM_CTX];
  collector_ctx_t        ctx_d [NUM_CTX];
  logic [PORT_BITS-1:0]  rr_q  [NUM_CTX];
  logic [PORT_BITS-1:0]  rr_d  [NUM_CTX];
  logic [DATA_WIDTH-1:0] data_q [NUM_CTX][NUM_PORTS];
  logic [CTX_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CTX_BITS:0]     cnt_q, cnt_d;
  logic                  lock_q, lock_d;
  logic [PORT_BITS-1:0]  sel_q, sel_d;

  collector_ctx_t        h;
  logic [NUM_PORTS-1:0]  sendable;
  logic [PORT_BITS-1:0]  rr_sel, sel;
  logic                  grant_any;
  logic                  dup, alloc;
  logic                  vvalid, vlast, vhs, retire;
  logic                  to_fire;
  logic [NUM_PORTS-1:0]  hit, rdy, wr, drop;
  logic [CTX_BITS-1:0]   hit_ctx [NUM_PORTS];

  assign h        = ctx_q[head_q];
  assign sendable = h.buf_mask & ~h.rcv_mask;

  response_collector_mt_rr_select #(
    .N (NUM_PORTS)
  ) u_rr (
    .req_i   (sendable),
    .last_i  (rr_q[head_q]),
    .grant_o (rr_sel),
    .any_o   (grant_any)
  );

  // a waiting value keeps its port until accepted
  assign sel = lock_q ? sel_q : rr_sel;

`ifdef RSP_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [SW-1:0] stall_q, stall_d;

  assign to_fire = h.valid
                && (stall_q == SW'(TIMEOUT_CYCLES - 1));

  // head stall count, held at the limit until accepted
  always_comb begin
    stall_d = stall_q;
    if (!h.valid || vhs)
      stall_d = '0;
    else if (!grant_any && !to_fire)
      stall_d = stall_q + SW'(1);
  end

  // stall counter register
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  assign vvalid = h.valid && (grant_any || to_fire);
  assign vlast  = to_fire
               || ((h.rcv_mask | onehot(sel)) == h.exp_mask);
  assign vhs    = vvalid && bus.value_ready;
  assign retire = vhs && vlast;

  // tag lookup for allocation and per-port response match
  always_comb begin
    dup = 1'b0;
    for (int c = 0; c < NUM_CTX; c++)
      if (ctx_q[c].valid && ctx_q[c].tag == bus.pending_tag)
        dup = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p]     = 1'b0;
      hit_ctx[p] = '0;
      for (int c = 0; c < NUM_CTX; c++)
        if (ctx_q[c].valid
            && ctx_q[c].tag == bus.port_data_tag[p]
            && ctx_q[c].exp_mask[p]
            && !ctx_q[c].rcv_mask[p]) begin
          hit[p]     = 1'b1;
          hit_ctx[p] = CTX_BITS'(c);
        end
      rdy[p]  = bus.port_data_valid[p]
             && (!hit[p] || !ctx_q[hit_ctx[p]].buf_mask[p]);
      wr[p]   = rdy[p] && hit[p];
      drop[p] = rdy[p] && !hit[p];
    end
  end

  assign bus.pending_ready = (cnt_q < (CTX_BITS+1)'(NUM_CTX))
                          && !dup;
  assign alloc = bus.pending_valid && bus.pending_ready
              && (bus.pending_mask != '0);

  // next state of context ring, pointers and count
  always_comb begin
    ctx_d  = ctx_q;
    rr_d   = rr_q;
    head_d = head_q;
    tail_d = tail_q;
    lock_d = vvalid && !bus.value_ready && !to_fire;
    sel_d  = sel;
    for (int p = 0; p < NUM_PORTS; p++)
      if (wr[p]) ctx_d[hit_ctx[p]].buf_mask[p] = 1'b1;
    if (vhs) begin
      if (!to_fire) begin
        ctx_d[head_q].rcv_mask[sel] = 1'b1;
        ctx_d[head_q].buf_mask[sel] = 1'b0;
        rr_d[head_q] = sel;
      end
      if (vlast) begin
        ctx_d[head_q].valid = 1'b0;
        head_d = head_q + CTX_BITS'(1);
      end
    end
    if (alloc) begin
      ctx_d[tail_q].valid    = 1'b1;
      ctx_d[tail_q].tag      = bus.pending_tag;
      ctx_d[tail_q].src_port = bus.pending_src_port;
      ctx_d[tail_q].exp_mask = bus.pending_mask;
      ctx_d[tail_q].rcv_mask = '0;
      ctx_d[tail_q].buf_mask = '0;
      rr_d[tail_q] = PORT_BITS'(NUM_PORTS - 1);
      tail_d = tail_q + CTX_BITS'(1);
    end
    cnt_d = cnt_q + (CTX_BITS+1)'(alloc)
                  - (CTX_BITS+1)'(retire);
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        ctx_q[c] <= '0;
        rr_q[c]  <= PORT_BITS'(NUM_PORTS - 1);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      ctx_q  <= ctx_d;
      rr_q   <= rr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
    end
  end

  // data slots, qualified by the context masks
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (wr[p]) data_q[hit_ctx[p]][p] <= bus.port_data[p];
  end

  assign bus.port_data_ready = rdy;
  assign bus.rsp_drop        = drop;
  assign bus.value_valid     = vvalid;
  assign bus.value_data      = to_fire ? '0 : data_q[head_q][sel];
  assign bus.value_tag       = h.tag;
  assign bus.value_src_port  = h.src_port;
  assign bus.value_last      = vvalid && vlast;
  assign bus.value_timeout   = vvalid && to_fire;
  assign bus.active_count    = cnt_q;
  assign bus.busy            = cnt_q != '0;

endmodule

// File: tb/tb_response_collector_mt.sv
// Directed bench for response_collector_mt.
// Cycle table plus hand-written multi-cycle sequences.
module tb_response_collector_mt;
  import response_collector_mt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  response_collector_mt_if #(.NUM_CTX(4)) bus ();

  response_collector_mt #(
    .NUM_CTX (4)
`ifdef RSP_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int pv, pm, pt, ps;
    int dv, dt, db, vr;
    int pr, pdr, drop, vv;
    int data, last, tag, src, act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int pv, pm, pt, ps, dv, dt, db, vr,
    input int pr, pdr, drop, vv, data, last,
    input int tag, src, act
  );
    vec_t v;
    v.pv = pv; v.pm = pm; v.pt = pt; v.ps = ps;
    v.dv = dv; v.dt = dt; v.db = db; v.vr = vr;
    v.pr = pr; v.pdr = pdr; v.drop = drop;
    v.vv = vv; v.data = data; v.last = last;
    v.tag = tag; v.src = src; v.act = act;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic vr);
    bus.pending_valid    = 1'b0;
    bus.pending_mask     = '0;
    bus.pending_tag      = '0;
    bus.pending_src_port = '0;
    bus.port_data_valid  = '0;
    bus.port_data        = '0;
    bus.port_data_tag    = '0;
    bus.value_ready      = vr;
  endtask

  task automatic req(input int m, input int t, input int s);
    bus.pending_valid    = 1'b1;
    bus.pending_mask     = 4'(m);
    bus.pending_tag      = 8'(t);
    bus.pending_src_port = 2'(s);
  endtask

  task automatic rsp(input int p, input int t, input int d);
    bus.port_data_valid[p] = 1'b1;
    bus.port_data_tag[p]   = 8'(t);
    bus.port_data[p]       = 16'(d);
  endtask

  task automatic apply(input int i, input vec_t v);
    string n;
    n = $sformatf("row%0d", i);
    idle(1'(v.vr));
    if (v.pv != 0) req(v.pm, v.pt, v.ps);
    for (int p = 0; p < NUM_PORTS; p++)
      if (v.dv[p]) rsp(p, v.dt, v.db + p);
    #1;
    chk({n, "_pend_rdy"}, 32'(bus.pending_ready), v.pr);
    chk({n, "_port_rdy"}, 32'(bus.port_data_ready), v.pdr);
    chk({n, "_drop"}, 32'(bus.rsp_drop), v.drop);
    chk({n, "_vvalid"}, 32'(bus.value_valid), v.vv);
    chk({n, "_active"}, 32'(bus.active_count), v.act);
    chk({n, "_tmo"}, 32'(bus.value_timeout), 0);
    if (v.vv != 0) begin
      chk({n, "_data"}, 32'(bus.value_data), v.data);
      chk({n, "_last"}, 32'(bus.value_last), v.last);
      chk({n, "_tag"}, 32'(bus.value_tag), v.tag);
      chk({n, "_src"}, 32'(bus.value_src_port), v.src);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    int n;

    // single context, mask 1011, rr order 0,1,3
    tbl.push_back(mk(1,4'b1011,5,2, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 4'b1011,5,'hA0,1,
                     1,4'b1011,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hA0,0,5,2,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hA1,0,5,2,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hA3,1,5,2,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,0));
    // unknown tag 9 on port 2
    tbl.push_back(mk(0,0,0,0, 4'b0100,9,0,1,
                     1,4'b0100,4'b0100,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,0));
    // tag 2 buffered early, held behind tag 1
    tbl.push_back(mk(1,4'b0011,1,0, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,4'b0100,2,1, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 4'b0100,2,'hB0,1,
                     1,4'b0100,0,0, 0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 4'b0011,1,'hB0,1,
                     1,4'b0011,0,0, 0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hB0,0,1,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hB1,1,1,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,1, 'hB2,1,2,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,
                     1,0,0,0, 0,0,0,0,0));

    idle(1'b1);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_pend_rdy", 32'(bus.pending_ready), 1);
    chk("rst_port_rdy", 32'(bus.port_data_ready), 0);
    chk("rst_vvalid", 32'(bus.value_valid), 0);
    chk("rst_last", 32'(bus.value_last), 0);
    chk("rst_tmo", 32'(bus.value_timeout), 0);
    chk("rst_drop", 32'(bus.rsp_drop), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_active", 32'(bus.active_count), 0);
    cyc();

    foreach (tbl[i]) apply(i, tbl[i]);

    // fill all four contexts, duplicate and full checks
    idle(1'b0);
    req(1, 10, 0);
    #1;
    chk("alloc10_rdy", 32'(bus.pending_ready), 1);
    cyc();
    #1;
    chk("dup_tag_rdy", 32'(bus.pending_ready), 0);
    req(1, 11, 0);
    cyc();
    req(1, 12, 0);
    cyc();
    req(1, 13, 0);
    cyc();
    req(1, 14, 0);
    #1;
    chk("full_rdy", 32'(bus.pending_ready), 0);
    chk("full_cnt", 32'(bus.active_count), 4);
    idle(1'b0);
    rsp(0, 10, 'hD0);
    #1;
    chk("head_rsp_rdy", 32'(bus.port_data_ready), 1);
    cyc();

    // held value stays stable while others buffer
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      if (i == 0) rsp(0, 11, 'hD1);
      #1;
      chk($sformatf("hold%0d_vv", i),
          32'(bus.value_valid), 1);
      chk($sformatf("hold%0d_data", i),
          32'(bus.value_data), 'hD0);
      chk($sformatf("hold%0d_last", i),
          32'(bus.value_last), 1);
      chk($sformatf("hold%0d_tag", i),
          32'(bus.value_tag), 10);
      cyc();
    end

    // retire tag 10, then reuse it while tag 11 retires
    idle(1'b1);
    req(1, 10, 0);
    #1;
    chk("reuse_before_rdy", 32'(bus.pending_ready), 0);
    cyc();
    #1;
    chk("reuse_rdy", 32'(bus.pending_ready), 1);
    chk("reuse_cnt", 32'(bus.active_count), 3);
    chk("next_head_vv", 32'(bus.value_valid), 1);
    chk("next_head_data", 32'(bus.value_data), 'hD1);
    chk("next_head_tag", 32'(bus.value_tag), 11);
    cyc();
    idle(1'b0);
    #1;
    chk("alloc_retire_cnt", 32'(bus.active_count), 3);
    chk("tag12_idle_vv", 32'(bus.value_valid), 0);

    // reset while a value is waiting
    rsp(0, 12, 'hD2);
    cyc();
    idle(1'b0);
    #1;
    chk("pre_rst_vv", 32'(bus.value_valid), 1);
    chk("pre_rst_data", 32'(bus.value_data), 'hD2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_vv", 32'(bus.value_valid), 0);
    chk("mid_rst_cnt", 32'(bus.active_count), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_rdy", 32'(bus.pending_ready), 1);
    cyc();
    #1;
    chk("post_rst_vv", 32'(bus.value_valid), 0);

`ifdef RSP_TIMEOUT_EN
    // only port 0 answers; head times out
    idle(1'b1);
    req(4'b0011, 7, 3);
    cyc();
    idle(1'b1);
    rsp(0, 7, 'hE0);
    cyc();
    idle(1'b1);
    #1;
    chk("tmo_first_vv", 32'(bus.value_valid), 1);
    chk("tmo_first_data", 32'(bus.value_data), 'hE0);
    chk("tmo_first_last", 32'(bus.value_last), 0);
    cyc();
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      #1;
      if (bus.value_valid === 1'b1) begin
        found = 1'b1;
        n = i;
      end else begin
        cyc();
      end
    end
    chk("tmo_seen", 32'(found), 1);
    chk("tmo_cycle", n, 16);
    chk("tmo_data", 32'(bus.value_data), 0);
    chk("tmo_last", 32'(bus.value_last), 1);
    chk("tmo_flag", 32'(bus.value_timeout), 1);
    cyc();
    idle(1'b1);
    rsp(1, 7, 'hE1);
    #1;
    chk("late_drop", 32'(bus.rsp_drop), 4'b0010);
    chk("late_cnt", 32'(bus.active_count), 0);
    cyc();
    idle(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
